// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//   Data-memory and memory-mapped I/O controller sitting behind the
//   processor's load/store port. Each request is decoded on ADDR[15:12]:
//     4'h0  internal RAM (2**AW x 16, index ADDR[AW-1:0], upper bits alias)
//     4'h1  LED register (write DOUT[9:0], read {6'b0, LEDR})
//     4'h3  switch input (read {6'b0, synchronised SW}, writes dropped)
//     other reads return 16'h0000, writes dropped
//   Writes complete in 1 cycle and reads in 1+RD_LAT cycles, each signalled
//   by a single-cycle Ready pulse. Mem holds the last read value.
//
// Ports
//   Clock    in   rising-edge clock
//   Reset    in   synchronous active-high reset (RAM contents kept)
//   Req      in   access request, only sampled while idle
//   ADDR     in   [15:0] access address
//   DOUT     in   [15:0] write data
//   W        in   1 = write, 0 = read
//   SW       in   [9:0] asynchronous switches
//   Mem      out  [15:0] registered read data
//   Ready    out  one-cycle completion pulse
//   Busy     out  access in flight
//   LEDR     out  [9:0] LED register
//   Overrun  out  sticky flag: Req seen while Busy
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int AW     = 7,
    parameter int RD_LAT = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    input  logic [9:0]  SW,
    output logic [15:0] Mem,
    output logic        Ready,
    output logic        Busy,
    output logic [9:0]  LEDR,
    output logic        Overrun
);

    localparam int         DEPTH    = 1 << AW;
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);
    localparam logic [3:0] REG_RAM  = 4'h0;
    localparam logic [3:0] REG_LED  = 4'h1;
    localparam logic [3:0] REG_SW   = 4'h3;

    typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, RD_DONE} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [9:0]  sw_meta;
    logic [9:0]  sw_sync;
    logic [15:0] ram [DEPTH];

    logic [3:0]    region_p0;
    logic [AW-1:0] idx_p0;
    logic [15:0]   dout_p0;
    logic [15:0]   rd_next;
    logic [15:0]   rd_p1;
    logic          ram_we;

    // Address bits between the RAM index and the region field only alias.
    logic unused_addr;
    assign unused_addr = ^ADDR[11:AW];

    assign Busy = (state != IDLE);

    // Switch synchroniser
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    // Stage p0: request fields captured at the acceptance edge
    always_ff @(posedge Clock) begin
        if (!Reset && state == IDLE && Req) begin
            region_p0 <= ADDR[15:12];
            idx_p0    <= ADDR[AW-1:0];
            dout_p0   <= DOUT;
        end
    end

    // RAM write port; no reset so contents survive Reset.
    assign ram_we = !Reset && state == WRITE && region_p0 == REG_RAM;

    always_ff @(posedge Clock) begin
        if (ram_we) begin
            ram[idx_p0] <= dout_p0;
        end
    end

    always_comb begin
        rd_next = 16'h0000;
        case (region_p0)
            REG_RAM: rd_next = ram[idx_p0];
            REG_LED: rd_next = {6'b0, LEDR};
            REG_SW:  rd_next = {6'b0, sw_sync};
            default: rd_next = 16'h0000;
        endcase
    end

    // Stage p1: read data captured on the last RD_WAIT cycle
    always_ff @(posedge Clock) begin
        if (state == RD_WAIT && cnt == 2'd0) begin
            rd_p1 <= rd_next;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            Mem     <= '0;
            Ready   <= 1'b0;
            LEDR    <= '0;
            Overrun <= 1'b0;
        end else begin
            Ready <= 1'b0;
            if (Req && state != IDLE) begin
                Overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (Req) begin
                        state <= W ? WRITE : RD_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                WRITE: begin
                    if (region_p0 == REG_LED) begin
                        LEDR <= dout_p0[9:0];
                    end
                    Ready <= 1'b1;
                    state <= IDLE;
                end
                RD_WAIT: begin
                    if (cnt == 2'd0) begin
                        state <= RD_DONE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RD_DONE: begin
                    Mem   <= rd_p1;
                    Ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Bench for data_mem_ctrl. One instance uses RD_LAT=1 and is driven from a
//   vector table; completions are matched against a scoreboard queue of
//   expected Mem values and completion cycles. A second instance with
//   RD_LAT=3 sees Req held high with alternating reads and writes.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int RD_LAT1 = 1;

    logic        clk;
    logic        rst;
    logic        req, w, req3, w3;
    logic [15:0] addr, dout, addr3, dout3;
    logic [9:0]  sw;
    logic [15:0] mem, mem3;
    logic        ready, busy, ovr, ready3, busy3, ovr3;
    logic [9:0]  ledr, ledr3;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int          due;
        logic [15:0] mem;
    } exp_t;

    typedef struct {
        logic        w;
        logic [15:0] addr;
        logic [15:0] dout;
        logic [9:0]  sw;
        logic [15:0] mem;
        logic [9:0]  ledr;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[16];
    logic prev_ready = 1'b0;

    data_mem_ctrl #(.AW(7), .RD_LAT(RD_LAT1)) u_dut (
        .Clock(clk), .Reset(rst), .Req(req), .ADDR(addr), .DOUT(dout), .W(w),
        .SW(sw), .Mem(mem), .Ready(ready), .Busy(busy), .LEDR(ledr), .Overrun(ovr)
    );

    data_mem_ctrl #(.AW(7), .RD_LAT(3)) u_dut3 (
        .Clock(clk), .Reset(rst), .Req(req3), .ADDR(addr3), .DOUT(dout3), .W(w3),
        .SW(sw), .Mem(mem3), .Ready(ready3), .Busy(busy3), .LEDR(ledr3), .Overrun(ovr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Completion monitor for the RD_LAT=1 instance
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            chk("ready_busy_excl", {31'b0, busy}, 32'd0);
            chk("ready_pulse_len", {31'b0, prev_ready}, 32'd0);
            if (sbq.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("ready_cycle", cyc, mon_e.due);
                chk("mem", {16'b0, mem}, {16'b0, mon_e.mem});
            end
        end
        prev_ready = (ready === 1'b1);
    end

    // One access on the RD_LAT=1 instance; the request inputs are scrambled
    // right after acceptance so the in-flight access must use latched values.
    task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input logic [9:0] s, input logic [15:0] em);
        exp_t e;
        bit   seen;
        @(posedge clk); #1;
        sw = s;
        repeat (2) begin @(posedge clk); #1; end
        w = wr; addr = a; dout = d; req = 1'b1;
        e.due = cyc + (wr ? 2 : 2 + RD_LAT1);
        e.mem = em;
        sbq.push_back(e);
        @(posedge clk); #1;
        req = 1'b0; w = ~wr; addr = ~a; dout = ~d;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ready === 1'b1) seen = 1;
        end
        if (!seen) chk("access_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ready3(output int at);
        at = -1;
        for (int i = 0; i < 20 && at < 0; i++) begin
            @(negedge clk);
            if (ready3 === 1'b1) at = cyc;
        end
        if (at < 0) chk("ready3_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t, tp, tn;
        logic [15:0] d3;

        //            w     addr      dout      sw      mem       ledr
        vecs[0]  = '{1'b1, 16'h0005, 16'hBEEF, 10'h000, 16'h0000, 10'h000};
        vecs[1]  = '{1'b0, 16'h0005, 16'h0000, 10'h000, 16'hBEEF, 10'h000};
        vecs[2]  = '{1'b0, 16'h0085, 16'h0000, 10'h000, 16'hBEEF, 10'h000};
        vecs[3]  = '{1'b1, 16'h0000, 16'h1111, 10'h000, 16'hBEEF, 10'h000};
        vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 10'h000, 16'h1111, 10'h000};
        vecs[5]  = '{1'b1, 16'h1000, 16'h03A5, 10'h000, 16'h1111, 10'h3A5};
        vecs[6]  = '{1'b0, 16'h1000, 16'h0000, 10'h000, 16'h03A5, 10'h3A5};
        vecs[7]  = '{1'b0, 16'h3000, 16'h0000, 10'h155, 16'h0155, 10'h3A5};
        vecs[8]  = '{1'b1, 16'h3000, 16'hFFFF, 10'h155, 16'h0155, 10'h3A5};
        vecs[9]  = '{1'b0, 16'h3000, 16'h0000, 10'h155, 16'h0155, 10'h3A5};
        vecs[10] = '{1'b0, 16'h7000, 16'h0000, 10'h155, 16'h0000, 10'h3A5};
        vecs[11] = '{1'b1, 16'h7000, 16'h2222, 10'h155, 16'h0000, 10'h3A5};
        vecs[12] = '{1'b0, 16'h0000, 16'h0000, 10'h155, 16'h1111, 10'h3A5};
        vecs[13] = '{1'b0, 16'h0F80, 16'h0000, 10'h155, 16'h1111, 10'h3A5};
        vecs[14] = '{1'b1, 16'h1000, 16'hFC00, 10'h155, 16'h1111, 10'h000};
        vecs[15] = '{1'b0, 16'h1000, 16'h0000, 10'h155, 16'h0000, 10'h000};

        // Reset held two cycles while a LED write is requested
        rst = 1'b1; req = 1'b1; w = 1'b1; addr = 16'h1000; dout = 16'h03FF; sw = '0;
        req3 = 1'b0; w3 = 1'b0; addr3 = '0; dout3 = '0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_mem",   {16'b0, mem},  32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_ledr",  {22'b0, ledr}, 32'd0);
        chk("rst_ovr",   {31'b0, ovr},  32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        chk("rst_no_write_ledr", {22'b0, ledr}, 32'd0);

        // Vector table
        for (int i = 0; i < 16; i++) begin
            access(vecs[i].w, vecs[i].addr, vecs[i].dout, vecs[i].sw, vecs[i].mem);
            chk($sformatf("ledr_v%0d", i), {22'b0, ledr}, {22'b0, vecs[i].ledr});
        end
        chk("ovr_single_req", {31'b0, ovr}, 32'd0);

        // Reset during RD_WAIT of a read
        @(posedge clk); #1;
        w = 1'b0; addr = 16'h0005; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy",  {31'b0, busy},  32'd0);
        chk("midrst_ready", {31'b0, ready}, 32'd0);
        chk("midrst_mem",   {16'b0, mem},   32'd0);
        repeat (4) @(negedge clk);
        access(1'b0, 16'h0005, 16'h0000, 10'h000, 16'hBEEF);
        chk("midrst_ledr", {22'b0, ledr}, 32'd0);

        // Req held high, alternating W, on the RD_LAT=3 instance
        @(posedge clk); #1;
        addr3 = 16'h0005; w3 = 1'b1; dout3 = 16'hA000; req3 = 1'b1; t = cyc;
        @(negedge clk); @(negedge clk);
        chk("ovr3_before", {31'b0, ovr3},  32'd0);
        chk("busy3_accept", {31'b0, busy3}, 32'd1);
        wait_ready3(tp);
        chk("wr3_first_lat", tp - t, 32'd2);
        chk("ovr3_set", {31'b0, ovr3}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            d3 = dout3;
            w3 = 1'b0;
            wait_ready3(tn);
            chk("rd3_interval", tn - tp, 32'd5);
            chk("rd3_mem", {16'b0, mem3}, {16'b0, d3});
            chk("rd3_busy", {31'b0, busy3}, 32'd0);
            tp = tn;
            w3 = 1'b1;
            dout3 = d3 + 16'd1;
            wait_ready3(tn);
            chk("wr3_interval", tn - tp, 32'd2);
            chk("wr3_mem_hold", {16'b0, mem3}, {16'b0, d3});
            tp = tn;
        end
        req3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovr3_sticky", {31'b0, ovr3}, 32'd1);
        chk("sbq_drained", sbq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
